// File: rtl/id_ex_decode_ctrl.sv
// RV32I decode stage and ID/EX pipeline register with load-use
// stall, taken-branch squash and illegal-opcode flagging.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ifid_instr/valid  instruction held in IF/ID
//   ex_branch_tkn     branch in EX taken; squash the ID slot
//   hazard_stall      comb load-use stall; pc/ifid write enables = ~stall
//   idex_*            registered control bundle and register indices
module id_ex_decode_ctrl #(
  parameter int ALUCTR_W  = 4,
  parameter int REG_AW    = 5,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         ifid_instr,
  input  logic                ifid_valid,
  input  logic                ex_branch_tkn,
  output logic                hazard_stall,
  output logic                pc_write_en,
  output logic                ifid_write_en,
  output logic                idex_valid,
  output logic                idex_branch,
  output logic                idex_memread,
  output logic                idex_memtoreg,
  output logic                idex_memwrite,
  output logic                idex_alusrc,
  output logic                idex_regwrite,
  output logic [1:0]          idex_ALUop,
  output logic [ALUCTR_W-1:0] idex_ALUctr,
  output logic [2:0]          idex_brf3,
  output logic [REG_AW-1:0]   idex_rs1,
  output logic [REG_AW-1:0]   idex_rs2,
  output logic [REG_AW-1:0]   idex_rd,
  output logic                idex_illegal
);

  typedef struct packed {
    logic                branch;
    logic                memread;
    logic                memtoreg;
    logic                memwrite;
    logic                alusrc;
    logic                regwrite;
    logic [1:0]          aluop;
    logic [ALUCTR_W-1:0] aluctr;
    logic [2:0]          brf3;
    logic                illegal;
  } ctrl_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [ALUCTR_W-1:0] A_ADD  = ALUCTR_W'(0);
  localparam logic [ALUCTR_W-1:0] A_SUB  = ALUCTR_W'(1);
  localparam logic [ALUCTR_W-1:0] A_AND  = ALUCTR_W'(2);
  localparam logic [ALUCTR_W-1:0] A_OR   = ALUCTR_W'(3);
  localparam logic [ALUCTR_W-1:0] A_XOR  = ALUCTR_W'(4);
  localparam logic [ALUCTR_W-1:0] A_SRL  = ALUCTR_W'(5);
  localparam logic [ALUCTR_W-1:0] A_SLL  = ALUCTR_W'(6);
  localparam logic [ALUCTR_W-1:0] A_SRA  = ALUCTR_W'(7);
  localparam logic [ALUCTR_W-1:0] A_SLT  = ALUCTR_W'(8);
  localparam logic [ALUCTR_W-1:0] A_SLTU = ALUCTR_W'(9);

  logic [6:0]        w_op;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [REG_AW-1:0] w_rd;
  logic              w_is_r;
  logic              w_is_ld;
  logic              w_is_st;
  logic              w_is_imm;
  logic              w_is_br;
  logic              w_rs2_used;
  logic              w_haz;
  logic              w_bubble;
  logic              w_bad;
  ctrl_t             w_raw;
  ctrl_t             w_dec;

  ctrl_t             r_ctrl;
  logic              r_valid;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;

  assign w_op  = ifid_instr[6:0];
  assign w_f3  = ifid_instr[14:12];
  assign w_f7  = ifid_instr[31:25];
  assign w_rs1 = REG_AW'(ifid_instr[19:15]);
  assign w_rs2 = REG_AW'(ifid_instr[24:20]);
  assign w_rd  = REG_AW'(ifid_instr[11:7]);

  assign w_is_r   = (w_op == OP_R);
  assign w_is_ld  = (w_op == OP_LD);
  assign w_is_st  = (w_op == OP_ST);
  assign w_is_imm = (w_op == OP_IMM);
  assign w_is_br  = (w_op == OP_BR);

  always_comb begin
    w_raw = '0;
    w_bad = 1'b0;
    unique case (1'b1)
      w_is_r: begin
        w_raw.regwrite = 1'b1;
        w_raw.aluop    = 2'b10;
        if (w_f7 != 7'h00 && w_f7 != 7'h20) w_bad = 1'b1;
        case ({w_f7[5], w_f3})
          4'b0000: w_raw.aluctr = A_ADD;
          4'b1000: w_raw.aluctr = A_SUB;
          4'b0001: w_raw.aluctr = A_SLL;
          4'b0010: w_raw.aluctr = A_SLT;
          4'b0011: w_raw.aluctr = A_SLTU;
          4'b0100: w_raw.aluctr = A_XOR;
          4'b0101: w_raw.aluctr = A_SRL;
          4'b1101: w_raw.aluctr = A_SRA;
          4'b0110: w_raw.aluctr = A_OR;
          4'b0111: w_raw.aluctr = A_AND;
          default: w_bad = 1'b1;
        endcase
      end
      w_is_ld: begin
        w_raw.memread  = 1'b1;
        w_raw.memtoreg = 1'b1;
        w_raw.regwrite = 1'b1;
        w_raw.alusrc   = 1'b1;
      end
      w_is_st: begin
        w_raw.memwrite = 1'b1;
        w_raw.alusrc   = 1'b1;
      end
      w_is_imm: begin
        w_raw.regwrite = 1'b1;
        w_raw.alusrc   = 1'b1;
        w_raw.aluop    = 2'b10;
        case (w_f3)
          3'b000:  w_raw.aluctr = A_ADD;
          3'b010:  w_raw.aluctr = A_SLT;
          3'b011:  w_raw.aluctr = A_SLTU;
          3'b100:  w_raw.aluctr = A_XOR;
          3'b110:  w_raw.aluctr = A_OR;
          3'b111:  w_raw.aluctr = A_AND;
          3'b001: begin
            w_raw.aluctr = A_SLL;
            if (w_f7 != 7'h00) w_bad = 1'b1;
          end
          default: begin
            if (w_f7 == 7'h00)      w_raw.aluctr = A_SRL;
            else if (w_f7 == 7'h20) w_raw.aluctr = A_SRA;
            else                    w_bad = 1'b1;
          end
        endcase
      end
      w_is_br: begin
        w_raw.branch = 1'b1;
        w_raw.aluop  = 2'b01;
        w_raw.aluctr = A_SUB;
        w_raw.brf3   = w_f3;
        if (w_f3 == 3'b010 || w_f3 == 3'b011) w_bad = 1'b1;
      end
      default: w_bad = 1'b1;
    endcase
  end

  // Unsupported encodings carry no side effects, only the flag.
  always_comb begin
    w_dec = w_raw;
    if (w_bad) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
  end

  assign w_rs2_used = w_is_r | w_is_st | w_is_br;

  assign w_haz = HAZARD_EN && r_valid && r_ctrl.memread
              && (r_rd != '0) && ifid_valid
              && ((w_rs1 == r_rd)
                  || (w_rs2_used && (w_rs2 == r_rd)));

  // A squashed (wrong-path) instruction never stalls.
  assign hazard_stall  = w_haz & ~ex_branch_tkn;
  assign pc_write_en   = ~hazard_stall;
  assign ifid_write_en = ~hazard_stall;

  assign w_bubble = ex_branch_tkn | hazard_stall | ~ifid_valid;

  // Indices load even on a bubble so forwarding sees them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
    end else begin
      r_rs1 <= w_rs1;
      r_rs2 <= w_rs2;
      r_rd  <= w_rd;
      if (w_bubble) begin
        r_ctrl  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_ctrl  <= w_dec;
        r_valid <= 1'b1;
      end
    end
  end

  assign idex_valid    = r_valid;
  assign idex_branch   = r_ctrl.branch;
  assign idex_memread  = r_ctrl.memread;
  assign idex_memtoreg = r_ctrl.memtoreg;
  assign idex_memwrite = r_ctrl.memwrite;
  assign idex_alusrc   = r_ctrl.alusrc;
  assign idex_regwrite = r_ctrl.regwrite;
  assign idex_ALUop    = r_ctrl.aluop;
  assign idex_ALUctr   = r_ctrl.aluctr;
  assign idex_brf3     = r_ctrl.brf3;
  assign idex_illegal  = r_ctrl.illegal;
  assign idex_rs1      = r_rs1;
  assign idex_rs2      = r_rs2;
  assign idex_rd       = r_rd;

endmodule

// File: tb/tb_id_ex_decode_ctrl.sv
// Randomized bench for id_ex_decode_ctrl against a table-driven
// reference model of the decode, hazard and pipeline rules.
module tb_id_ex_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        ex_branch_tkn;
  logic        hazard_stall;
  logic        pc_write_en;
  logic        ifid_write_en;
  logic        idex_valid;
  logic        idex_branch;
  logic        idex_memread;
  logic        idex_memtoreg;
  logic        idex_memwrite;
  logic        idex_alusrc;
  logic        idex_regwrite;
  logic [1:0]  idex_ALUop;
  logic [3:0]  idex_ALUctr;
  logic [2:0]  idex_brf3;
  logic [4:0]  idex_rs1;
  logic [4:0]  idex_rs2;
  logic [4:0]  idex_rd;
  logic        idex_illegal;

  id_ex_decode_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifid_instr   (ifid_instr),
    .ifid_valid   (ifid_valid),
    .ex_branch_tkn(ex_branch_tkn),
    .hazard_stall (hazard_stall),
    .pc_write_en  (pc_write_en),
    .ifid_write_en(ifid_write_en),
    .idex_valid   (idex_valid),
    .idex_branch  (idex_branch),
    .idex_memread (idex_memread),
    .idex_memtoreg(idex_memtoreg),
    .idex_memwrite(idex_memwrite),
    .idex_alusrc  (idex_alusrc),
    .idex_regwrite(idex_regwrite),
    .idex_ALUop   (idex_ALUop),
    .idex_ALUctr  (idex_ALUctr),
    .idex_brf3    (idex_brf3),
    .idex_rs1     (idex_rs1),
    .idex_rs2     (idex_rs2),
    .idex_rd      (idex_rd),
    .idex_illegal (idex_illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // -1 marks an illegal encoding
  int rtab [16] = '{0, 6, 8, 9, 4, 5, 3, 2,
                    1, -1, -1, -1, -1, 7, -1, -1};
  int itab [8]  = '{0, 6, 8, 9, 4, 5, 3, 2};

  logic [6:0] ops [7] = '{7'h33, 7'h03, 7'h23, 7'h13,
                          7'h63, 7'h37, 7'h6f};

  logic [15:0] m_ctrl;
  logic        m_valid;
  logic [14:0] m_regs;
  logic        obs_stall;
  logic        last_stall;
  logic [15:0] dut_ctrl;

  assign dut_ctrl = {idex_branch, idex_memread, idex_memtoreg,
                     idex_memwrite, idex_alusrc, idex_regwrite,
                     idex_ALUop, idex_ALUctr, idex_brf3,
                     idex_illegal};

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {br,mr,mtr,mw,as,rw,aluop[2],ctr[4],brf3[3],ill}
  function automatic logic [15:0] ref_dec(logic [31:0] in);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         ctr;
    logic       br, mr, mtr, mw, as, rw;
    logic [1:0] aop;
    logic [2:0] bf;
    logic [3:0] c4;
    op = in[6:0];
    f3 = in[14:12];
    f7 = in[31:25];
    ctr = -1;
    {br, mr, mtr, mw, as, rw} = '0;
    aop = 2'b00;
    bf  = 3'b000;
    case (op)
      7'h33: begin
        if (f7 == 7'h00 || f7 == 7'h20) ctr = rtab[{f7[5], f3}];
        rw = 1; aop = 2'b10;
      end
      7'h03: begin ctr = 0; mr = 1; mtr = 1; rw = 1; as = 1; end
      7'h23: begin ctr = 0; mw = 1; as = 1; end
      7'h13: begin
        ctr = itab[f3];
        if (f3 == 3'd1 && f7 != 7'h00) ctr = -1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20)      ctr = 7;
          else if (f7 != 7'h00) ctr = -1;
        end
        as = 1; rw = 1; aop = 2'b10;
      end
      7'h63: begin
        if (f3 != 3'd2 && f3 != 3'd3) ctr = 1;
        br = 1; aop = 2'b01; bf = f3;
      end
      default: ctr = -1;
    endcase
    if (ctr < 0) return 16'h0001;
    c4 = ctr[3:0];
    return {br, mr, mtr, mw, as, rw, aop, c4, bf, 1'b0};
  endfunction

  function automatic logic ref_stall(logic [31:0] in, logic v,
                                     logic bt);
    logic uses2;
    logic [4:0] rd;
    uses2 = (in[6:0] == 7'h33) || (in[6:0] == 7'h23)
         || (in[6:0] == 7'h63);
    rd = m_regs[4:0];
    if (bt || !v || !m_valid || !m_ctrl[14] || rd == 0)
      return 1'b0;
    return (in[19:15] == rd) || (uses2 && in[24:20] == rd);
  endfunction

  // called 1 time unit after a rising edge
  task automatic step(logic [31:0] ins, logic v, logic bt);
    logic st;
    ifid_instr    = ins;
    ifid_valid    = v;
    ex_branch_tkn = bt;
    @(negedge clk);
    st = ref_stall(ins, v, bt);
    obs_stall = hazard_stall;
    check("stall", hazard_stall, st);
    check("pc_we", pc_write_en, !st);
    check("ifid_we", ifid_write_en, !st);
    m_regs = {ins[19:15], ins[24:20], ins[11:7]};
    if (bt || st || !v) begin
      m_valid = 0;
      m_ctrl  = '0;
    end else begin
      m_valid = 1;
      m_ctrl  = ref_dec(ins);
    end
    @(posedge clk);
    #1;
    check("valid", idex_valid, m_valid);
    check("ctrl", dut_ctrl, m_ctrl);
    check("regs", {idex_rs1, idex_rs2, idex_rd}, m_regs);
    last_stall = st;
  endtask

  function automatic logic [31:0] rtype(logic [6:0] f7,
      logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3,
      logic [4:0] rd, logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] gen();
    logic [6:0] f7;
    logic [6:0] op;
    int k;
    op = ops[$urandom_range(0, 6)];
    k  = $urandom_range(0, 9);
    f7 = (k < 5) ? 7'h00 : (k < 9) ? 7'h20 : 7'($urandom);
    return rtype(f7, 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 3'($urandom),
                 5'($urandom_range(0, 3)), op);
  endfunction

  initial begin
    logic [31:0] ins;
    logic        v;
    logic        bt;
    rst_n = 0;
    ifid_instr = '0;
    ifid_valid = 0;
    ex_branch_tkn = 0;
    m_ctrl = '0; m_valid = 0; m_regs = '0;
    last_stall = 0; obs_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", idex_valid, 0);
    check("rst_ctrl", dut_ctrl, 0);
    check("rst_pcwe", pc_write_en, 1);
    rst_n = 1;

    // load-use: lw x5,0(x1); add x6,x5,x2
    step(rtype(7'h0, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03), 1, 0);
    step(rtype(7'h0, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33), 1, 0);
    check("t2_stall", obs_stall, 1);
    check("t2_bubble", idex_valid, 0);
    step(rtype(7'h0, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33), 1, 0);
    check("t2_nostall", obs_stall, 0);
    check("t2_issue", {idex_valid, idex_ALUctr}, {1'b1, 4'd0});

    // lw x0 never stalls; addi ignores its rs2 field
    step(rtype(7'h0, 5'd0, 5'd1, 3'd2, 5'd0, 7'h03), 1, 0);
    step(rtype(7'h0, 5'd2, 5'd0, 3'd0, 5'd6, 7'h33), 1, 0);
    check("t3_x0", obs_stall, 0);
    step(rtype(7'h0, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03), 1, 0);
    step(rtype(7'h0, 5'd5, 5'd7, 3'd0, 5'd6, 7'h13), 1, 0);
    check("t3_imm", obs_stall, 0);

    // squash beats the stall
    step(rtype(7'h0, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03), 1, 0);
    step(rtype(7'h0, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33), 1, 1);
    check("t4_stall", obs_stall, 0);
    check("t4_bubble", idex_valid, 0);

    // ALU sweep
    step(rtype(7'h20, 5'd2, 5'd1, 3'd5, 5'd3, 7'h33), 1, 0);
    check("sra", idex_ALUctr, 7);
    step(rtype(7'h0, 5'd9, 5'd1, 3'd3, 5'd3, 7'h13), 1, 0);
    check("sltiu", idex_ALUctr, 9);
    step(rtype(7'h20, 5'd3, 5'd1, 3'd5, 5'd3, 7'h13), 1, 0);
    check("srai", idex_ALUctr, 7);
    step(rtype(7'h7f, 5'd31, 5'd1, 3'd7, 5'd3, 7'h13), 1, 0);
    check("andi", idex_ALUctr, 2);
    step(rtype(7'h0, 5'd2, 5'd1, 3'd1, 5'd8, 7'h63), 1, 0);
    check("bne", {idex_brf3, idex_ALUctr}, {3'd1, 4'd1});

    // illegal encodings
    step(rtype(7'h0, 5'd2, 5'd1, 3'd0, 5'd3, 7'h37), 1, 0);
    check("lui_ill", {idex_illegal, idex_regwrite,
                      idex_memwrite}, 3'b100);
    step(rtype(7'h20, 5'd2, 5'd1, 3'd7, 5'd3, 7'h33), 1, 0);
    check("r_ill", {idex_illegal, idex_regwrite,
                    idex_memwrite}, 3'b100);

    // async reset mid-stream
    step(rtype(7'h0, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03), 1, 0);
    @(negedge clk);
    ifid_instr = rtype(7'h0, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33);
    rst_n = 0;
    #1;
    check("arst_valid", idex_valid, 0);
    check("arst_ctrl", dut_ctrl, 0);
    check("arst_regs", {idex_rs1, idex_rs2, idex_rd}, 0);
    check("arst_pcwe", pc_write_en, 1);
    @(posedge clk);
    #1;
    rst_n = 1;
    m_ctrl = '0; m_valid = 0; m_regs = '0;
    last_stall = 0;

    ins = '0; v = 0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        ins = gen();
        v   = ($urandom_range(0, 7) != 0);
      end
      bt = ($urandom_range(0, 7) == 0);
      step(ins, v, bt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
